// File: rtl/dec_seq_if.sv
// Control and select bundle for dec_seq: the master drives the commands, the slave
// returns the registered one-hot select, the index and the status pulses.
interface dec_seq_if #(
  parameter int SEL_W = 2
);
  localparam int NUM_OUT = 1 << SEL_W;

  logic               clear;
  logic               load;
  logic [SEL_W-1:0]   load_idx;
  logic               step;
  logic               dir;
  logic [NUM_OUT-1:0] out;
  logic [SEL_W-1:0]   idx;
  logic               active;
  logic               wrapped;
  logic               blocked;

  modport master (
    output clear, load, load_idx, step, dir,
    input  out, idx, active, wrapped, blocked
  );

  modport slave (
    input  clear, load, load_idx, step, dir,
    output out, idx, active, wrapped, blocked
  );
endinterface

// File: rtl/dec_seq.sv
// Registered one-hot select generator: loads an index, steps it up or down, and
// either wraps or refuses the step at the ends (WRAP), pulsing wrapped/blocked.
module dec_seq #(
  parameter int SEL_W = 2,
  parameter bit WRAP  = 1'b1
) (
  input logic      clock,
  input logic      reset,
  dec_seq_if.slave bus
);
  localparam int               NUM_OUT = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_reg;
  logic [SEL_W-1:0]   idx_reg;
  logic [NUM_OUT-1:0] out_reg;
  logic               active_reg;
  logic               wrapped_reg;
  logic               blocked_reg;

  logic [SEL_W-1:0]   step_idx;
  logic               at_bound;
  logic [NUM_OUT-1:0] load_hot;
  logic [NUM_OUT-1:0] step_hot;

  // The step target always derives from the registered index, never from load_idx.
  always_comb begin
    step_idx = bus.dir ? (idx_reg - IDX_ONE) : (idx_reg + IDX_ONE);
    at_bound = bus.dir ? (idx_reg == '0) : (idx_reg == IDX_MAX);
  end

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_hot
      assign load_hot[gi] = (bus.load_idx == SEL_W'(gi));
      assign step_hot[gi] = (step_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      out_reg     <= '0;
      active_reg  <= 1'b0;
      wrapped_reg <= 1'b0;
      blocked_reg <= 1'b0;
    end else begin
      wrapped_reg <= 1'b0;
      blocked_reg <= 1'b0;
      if (bus.clear) begin
        state_reg  <= IDLE;
        idx_reg    <= '0;
        out_reg    <= '0;
        active_reg <= 1'b0;
      end else if (bus.load) begin
        state_reg  <= ACTIVE;
        idx_reg    <= bus.load_idx;
        out_reg    <= load_hot;
        active_reg <= 1'b1;
      end else if (bus.step && state_reg == ACTIVE) begin
        if (at_bound && !WRAP) begin
          blocked_reg <= 1'b1;
        end else begin
          // Reaching here with at_bound set is only possible when WRAP=1.
          idx_reg     <= step_idx;
          out_reg     <= step_hot;
          wrapped_reg <= at_bound;
        end
      end
    end
  end

  assign bus.out     = out_reg;
  assign bus.idx     = idx_reg;
  assign bus.active  = active_reg;
  assign bus.wrapped = wrapped_reg;
  assign bus.blocked = blocked_reg;
endmodule

// File: tb/tb_dec_seq.sv
// Self-checking bench for dec_seq: a shared vector table drives a wrapping and a
// saturating SEL_W=2 instance; a SEL_W=3 instance covers the sweep and async reset.
module tb_dec_seq;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dec_seq_if #(.SEL_W(2)) bw ();
  dec_seq_if #(.SEL_W(2)) bs ();
  dec_seq_if #(.SEL_W(3)) b3 ();

  dec_seq #(.SEL_W(2), .WRAP(1'b1)) u_wrap (.clock(clock), .reset(reset), .bus(bw.slave));
  dec_seq #(.SEL_W(2), .WRAP(1'b0)) u_sat  (.clock(clock), .reset(reset), .bus(bs.slave));
  dec_seq #(.SEL_W(3), .WRAP(1'b1)) u_big  (.clock(clock), .reset(reset), .bus(b3.slave));

  // Expected packing: {out, idx, active, wrapped, blocked}
  typedef struct {
    logic       clear;
    logic       load;
    logic [1:0] load_idx;
    logic       step;
    logic       dir;
    logic [8:0] exp_w;
    logic [8:0] exp_s;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   wrap_count;
  logic [7:0] eo;
  logic [2:0] ei;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    checks++;
    if (actual !== expect_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, expect_v);
    end
  endtask

  task automatic add(input logic cl, input logic ld, input logic [1:0] li, input logic st,
                     input logic dr, input logic [3:0] wo, input logic [1:0] wi, input logic ww,
                     input logic [3:0] so, input logic [1:0] si, input logic sb, input logic a);
    vec_t v;
    v.clear    = cl;
    v.load     = ld;
    v.load_idx = li;
    v.step     = st;
    v.dir      = dr;
    v.exp_w    = {wo, wi, a, ww, 1'b0};
    v.exp_s    = {so, si, a, 1'b0, sb};
    tbl.push_back(v);
  endtask

  task automatic drive_big(input logic cl, input logic ld, input logic [2:0] li,
                           input logic st, input logic dr);
    b3.clear    = cl;
    b3.load     = ld;
    b3.load_idx = li;
    b3.step     = st;
    b3.dir      = dr;
  endtask

  initial begin
    //   cl ld li st dr | wrap: out     idx w | sat: out     idx b | act
    add(0, 0, 0, 1, 0,  4'b0000, 0, 0,  4'b0000, 0, 0,  0); // step in IDLE ignored
    add(0, 1, 2, 0, 0,  4'b0100, 2, 0,  4'b0100, 2, 0,  1);
    add(0, 0, 0, 1, 0,  4'b1000, 3, 0,  4'b1000, 3, 0,  1);
    add(0, 0, 0, 1, 0,  4'b0001, 0, 1,  4'b1000, 3, 1,  1); // top boundary
    add(0, 0, 0, 1, 0,  4'b0010, 1, 0,  4'b1000, 3, 1,  1); // blocked held
    add(0, 0, 0, 0, 0,  4'b0010, 1, 0,  4'b1000, 3, 0,  1);
    add(0, 1, 3, 1, 0,  4'b1000, 3, 0,  4'b1000, 3, 0,  1); // reload, step ignored
    add(0, 0, 0, 1, 0,  4'b0001, 0, 1,  4'b1000, 3, 1,  1);
    add(0, 0, 0, 1, 1,  4'b1000, 3, 1,  4'b0100, 2, 0,  1); // wrap down
    add(0, 1, 0, 0, 0,  4'b0001, 0, 0,  4'b0001, 0, 0,  1);
    add(0, 0, 0, 1, 1,  4'b1000, 3, 1,  4'b0001, 0, 1,  1); // bottom boundary
    add(0, 0, 0, 1, 1,  4'b0100, 2, 0,  4'b0001, 0, 1,  1);
    add(0, 0, 0, 1, 0,  4'b1000, 3, 0,  4'b0010, 1, 0,  1);
    add(0, 1, 1, 0, 0,  4'b0010, 1, 0,  4'b0010, 1, 0,  1);
    add(1, 1, 3, 1, 0,  4'b0000, 0, 0,  4'b0000, 0, 0,  0); // clear wins
    add(0, 1, 3, 1, 0,  4'b1000, 3, 0,  4'b1000, 3, 0,  1); // load beats step
    add(1, 0, 0, 0, 0,  4'b0000, 0, 0,  4'b0000, 0, 0,  0);
    add(0, 0, 0, 1, 1,  4'b0000, 0, 0,  4'b0000, 0, 0,  0); // no pulse in IDLE
    add(0, 1, 3, 0, 0,  4'b1000, 3, 0,  4'b1000, 3, 0,  1);
    add(0, 0, 0, 1, 0,  4'b0001, 0, 1,  4'b1000, 3, 1,  1);
    add(1, 0, 0, 0, 0,  4'b0000, 0, 0,  4'b0000, 0, 0,  0); // clear kills pulse

    reset = 1'b1;
    bw.clear = 0; bw.load = 0; bw.load_idx = 0; bw.step = 0; bw.dir = 0;
    bs.clear = 0; bs.load = 0; bs.load_idx = 0; bs.step = 0; bs.dir = 0;
    drive_big(0, 0, 0, 0, 0);

    #12;
    chk("reset_wrap", 32'({bw.out, bw.idx, bw.active, bw.wrapped, bw.blocked}), 32'd0);
    chk("reset_sat",  32'({bs.out, bs.idx, bs.active, bs.wrapped, bs.blocked}), 32'd0);
    chk("reset_big",  32'({b3.out, b3.idx, b3.active, b3.wrapped, b3.blocked}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      bw.clear = tbl[i].clear; bw.load = tbl[i].load; bw.load_idx = tbl[i].load_idx;
      bw.step  = tbl[i].step;  bw.dir  = tbl[i].dir;
      bs.clear = tbl[i].clear; bs.load = tbl[i].load; bs.load_idx = tbl[i].load_idx;
      bs.step  = tbl[i].step;  bs.dir  = tbl[i].dir;
      @(posedge clock);
      #1;
      $display("row %0d: wrap out=%b idx=%0d w=%b | sat out=%b idx=%0d b=%b", i,
               bw.out, bw.idx, bw.wrapped, bs.out, bs.idx, bs.blocked);
      chk($sformatf("row%0d_wrap", i),
          32'({bw.out, bw.idx, bw.active, bw.wrapped, bw.blocked}), 32'(tbl[i].exp_w));
      chk($sformatf("row%0d_sat", i),
          32'({bs.out, bs.idx, bs.active, bs.wrapped, bs.blocked}), 32'(tbl[i].exp_s));
    end

    // Full up-sweep on the 3-bit instance, ending in exactly one wrap.
    @(negedge clock);
    drive_big(0, 1, 0, 0, 0);
    @(posedge clock);
    #1;
    chk("sweep_load", 32'({b3.out, b3.idx, b3.active}), 32'({8'b0000_0001, 3'd0, 1'b1}));
    wrap_count = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      drive_big(0, 0, 0, 1, 0);
      @(posedge clock);
      #1;
      eo = 8'b0000_0001 << (k % 8);
      ei = 3'(k % 8);
      if (b3.wrapped) wrap_count++;
      $display("sweep %0d: out=%b idx=%0d wrapped=%b", k, b3.out, b3.idx, b3.wrapped);
      chk($sformatf("sweep%0d", k), 32'({b3.out, b3.idx, b3.active, b3.wrapped, b3.blocked}),
          32'({eo, ei, 1'b1, (k == 8), 1'b0}));
      chk($sformatf("sweep%0d_onehot", k), 32'($onehot(b3.out)), 32'd1);
    end
    chk("sweep_wrap_count", 32'(wrap_count), 32'd1);

    // Async reset landing between edges while stepping at idx=5.
    @(negedge clock);
    drive_big(0, 1, 3, 0, 0);
    @(negedge clock);
    drive_big(0, 0, 0, 1, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pre_reset_idx5", 32'({b3.out, b3.idx, b3.active}), 32'({8'b0010_0000, 3'd5, 1'b1}));
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: out=%b idx=%0d active=%b", b3.out, b3.idx, b3.active);
    chk("async_reset", 32'({b3.out, b3.idx, b3.active, b3.wrapped, b3.blocked}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    $display("post reset step: out=%b idx=%0d active=%b", b3.out, b3.idx, b3.active);
    chk("post_reset_step", 32'({b3.out, b3.idx, b3.active, b3.wrapped, b3.blocked}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
